csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Initiator side of the CSR interface. Accepts one SYSTEM-opcode instruction at a time from decode over a valid/ready handshake and decodes CSRRW/CSRRS/CSRRC and their immediate forms. Sequences the read-then-write access against the CSR register file, whose read data is registered, and returns the old CSR value to writeback over a second valid/ready handshake. Sits between decode/execute and the `csr` register file.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `instr_valid` in 1: decode offers an instruction.
- `instr_ready` out 1: unit can accept an instruction.
- `instr` in 32: raw instruction word.
- `rs1_data` in 32: register rs1 value, sampled on accept.
- `csr_wr_en` out 1: write strobe to the CSR file.
- `csr_op` out 3: bit 2 selects immediate; bits [1:0] are 00 NOP, 01 RW, 10 RS, 11 RC.
- `csr_uimm` out 5: zero-extended immediate (instr[19:15]).
- `csr_addr` out 12: CSR address (instr[31:20]).
- `csr_data_in` out 32: latched rs1_data.
- `csr_data_out` in 32: registered read data from the CSR file, valid one cycle after `csr_addr`.
- `wb_valid` out 1: result available.
- `wb_ready` in 1: writeback accepts the result.
- `wb_rd` out 5: destination register (instr[11:7]).
- `wb_data` out 32: old CSR value.
- `wb_we` out 1: register write required (rd != 0 and not illegal).
- `illegal` out 1: instruction rejected; qualified by wb_valid.

## Operation
- States: IDLE, READ, WRITE, RESP, ERR.
- Reset: state IDLE. All outputs and latched fields are 0, except `instr_ready`, which is 1.
- IDLE: `instr_ready=1`. On `instr_valid&&instr_ready`, latch instr and rs1_data.
  - Legal instruction: opcode 7'b1110011 and funct3 in {001,010,011,101,110,111}. Go to READ.
  - Otherwise: go to ERR.
- READ (1 cycle): drive `csr_addr`, `csr_op=3'b000`, `csr_wr_en=0`. Go to WRITE.
- WRITE (1 cycle): drive `csr_addr`, `csr_op=funct3`, `csr_uimm`, `csr_data_in`.
  - `csr_wr_en=1` unless funct3[1:0] is RS or RC and the rs1/uimm field is 0 (no-write rule). In that case `csr_wr_en=0` and `csr_op[1:0]=00`.
  - Capture `csr_data_out` into `wb_data`. Go to RESP.
- RESP: `wb_valid=1`; `wb_rd`, `wb_data` and `wb_we` are stable. On `wb_ready`, go to IDLE.
- ERR: `wb_valid=1`, `illegal=1`, `wb_we=0`, `wb_data=0`. No CSR signal asserted. On `wb_ready`, go to IDLE.
- Outside READ/WRITE: `csr_wr_en=0`, `csr_op=000`, `csr_addr=0`.
- At most one instruction in flight. `instr_ready=0` in every state except IDLE.

## Timing
- Legal access accepted at edge N:
  - READ during cycle N+1.
  - WRITE with `csr_wr_en` during cycle N+2.
  - `wb_valid` from cycle N+3.
  - `wb_valid` holds until the `wb_valid&&wb_ready` edge. The next instruction can be accepted one cycle after that edge.
- Illegal instruction accepted at edge N: `wb_valid=1`, `illegal=1` from cycle N+1.
- `csr_wr_en` is high for exactly one cycle per writing instruction.
- Asserting `rst` mid-operation returns to IDLE immediately. Any pending write is dropped unless its WRITE cycle already completed at an edge.
- `wb_ready` held high in RESP: handshake completes in one cycle. Backpressure holds all wb_* outputs constant.

## Configuration
- `CSR_RO_CHECK_EN` defined: a write-intent instruction to an address with addr[11:10]==2'b11 is treated as illegal.
  - Write intent means RW, or RS/RC with a nonzero rs1/uimm field.
  - Flow: IDLE → ERR, no CSR access.
  - Read-only-intent accesses to the same range proceed normally.
- `CSR_RO_CHECK_EN` not defined: no address check. All legal-funct3 accesses are issued to the CSR file.

## Test plan
- CSRRW x5, 0x309, rs1_data=0xDEADBEEF, CSR value 0x12: `csr_wr_en` pulse in cycle N+2 with op=001 and data_in=0xDEADBEEF. Then `wb_valid` with rd=5, data=0x12, we=1.
- CSRRS x3, 0x309, rs1 field=0 (CSR value 0xA5): `csr_wr_en` stays 0 throughout. wb_data=0xA5, we=1.
- CSRRCI x0, 0x309, uimm=0x1F: `csr_op=111`, `csr_uimm=0x1F`, one write pulse. `wb_we=0`.
- Illegal opcode, or funct3=100: `wb_valid` and `illegal` in cycle N+1, no CSR activity. With `CSR_RO_CHECK_EN`, CSRRW to 0xC00 also flags illegal. Without the macro, the same instruction issues a write.
- Hold `wb_ready=0` for 5 cycles in RESP: outputs stable and `instr_ready=0`. Release: handshake completes, and the next instruction is accepted the following cycle.
- Assert `rst` during READ: state IDLE, `csr_wr_en` never pulses, `instr_ready=1`, all other outputs 0.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// Bundle of the decode handshake, CSR register-file port and writeback handshake
// seen by csr_access_unit; the unit connects through the slave modport.
interface csr_access_unit_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic        csr_wr_en;
    logic [2:0]  csr_op;
    logic [4:0]  csr_uimm;
    logic [11:0] csr_addr;
    logic [31:0] csr_data_in;
    logic [31:0] csr_data_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        illegal;

    modport master (
        output instr_valid, instr, rs1_data, csr_data_out, wb_ready,
        input  instr_ready, csr_wr_en, csr_op, csr_uimm, csr_addr, csr_data_in,
               wb_valid, wb_rd, wb_data, wb_we, illegal
    );

    modport slave (
        input  instr_valid, instr, rs1_data, csr_data_out, wb_ready,
        output instr_ready, csr_wr_en, csr_op, csr_uimm, csr_addr, csr_data_in,
               wb_valid, wb_rd, wb_data, wb_we, illegal
    );
endinterface

// File: rtl/csr_access_unit.sv
// CSR access sequencer: decodes one CSRRx/CSRRxI at a time, reads then writes the CSR file,
// and returns the old value. Optional macro CSR_RO_CHECK_EN rejects writes to addr[11:10]==2'b11.
module csr_access_unit (
    input  logic             clk,
    input  logic             rst,
    csr_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

    state_t      state, next_state;
    logic [11:0] q_addr;
    logic [4:0]  q_field;
    logic [2:0]  q_funct3;
    logic [4:0]  q_rd;
    logic [31:0] q_rs1;
    logic [31:0] q_rdata;

    logic       accept;
    logic       legal;
    logic       no_write;
    logic [2:0] in_funct3;

    assign in_funct3 = bus.instr[14:12];
    assign accept    = bus.instr_valid && (state == IDLE);

    always_comb begin
        legal = (bus.instr[6:0] == 7'b1110011) &&
                (in_funct3 != 3'b000) && (in_funct3 != 3'b100);
`ifdef CSR_RO_CHECK_EN
        // Write intent into the read-only quadrant: RW always, RS/RC only with a nonzero source.
        if ((bus.instr[31:30] == 2'b11) &&
            ((in_funct3[1:0] == 2'b01) || (in_funct3[1] && (bus.instr[19:15] != 5'd0))))
            legal = 1'b0;
`endif
    end

    // RS/RC with a zero source field must not disturb the CSR (side-effect-free read).
    assign no_write = q_funct3[1] && (q_field == 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr   <= '0;
            q_field  <= '0;
            q_funct3 <= '0;
            q_rd     <= '0;
            q_rs1    <= '0;
            q_rdata  <= '0;
        end else begin
            if (accept) begin
                q_addr   <= bus.instr[31:20];
                q_field  <= bus.instr[19:15];
                q_funct3 <= in_funct3;
                q_rd     <= bus.instr[11:7];
                q_rs1    <= bus.rs1_data;
            end
            if (state == WRITE) q_rdata <= bus.csr_data_out;
        end
    end

    // NOTE: next_state gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = legal ? READ : ERR;
            READ:    next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    if (bus.wb_ready) next_state = IDLE;
            ERR:     if (bus.wb_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = 1'b0;
        bus.csr_wr_en   = 1'b0;
        bus.csr_op      = 3'b000;
        bus.csr_uimm    = 5'd0;
        bus.csr_addr    = 12'd0;
        bus.csr_data_in = 32'd0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.wb_data     = 32'd0;
        bus.wb_we       = 1'b0;
        bus.illegal     = 1'b0;
        case (state)
            IDLE:  bus.instr_ready = 1'b1;
            READ:  bus.csr_addr = q_addr;
            WRITE: begin
                bus.csr_addr    = q_addr;
                bus.csr_uimm    = q_field;
                bus.csr_data_in = q_rs1;
                bus.csr_wr_en   = !no_write;
                bus.csr_op      = no_write ? {q_funct3[2], 2'b00} : q_funct3;
            end
            RESP: begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = q_rd;
                bus.wb_data  = q_rdata;
                bus.wb_we    = (q_rd != 5'd0);
            end
            ERR: begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = q_rd;
                bus.illegal  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a registered-read CSR file model;
// expectations follow the RO-check macro CSR_RO_CHECK_EN when it is defined.
module tb_csr_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    csr_access_unit_if bus();

    csr_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          wr_count    = 0;
    logic [31:0] csr309      = 32'd0;

    // Registered-read CSR file: data for csr_addr appears the cycle after.
    always @(posedge clk)
        bus.csr_data_out <= (bus.csr_addr == 12'h309) ? csr309 : 32'h0000_0077;

    always @(posedge clk)
        if (bus.csr_wr_en) wr_count <= wr_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
        return {a, r1, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] ins, input logic [31:0] rs1);
        bus.instr       = ins;
        bus.rs1_data    = rs1;
        bus.instr_valid = 1'b1;
        step();
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.rs1_data    = 32'd0;
    endtask

    task automatic legal_txn(input string tag, input logic [31:0] ins, input logic [31:0] rs1,
                             input logic [31:0] csrval, input logic [11:0] exp_addr,
                             input logic exp_wr, input logic [2:0] exp_op,
                             input logic [4:0] exp_uimm, input logic [4:0] exp_rd,
                             input logic exp_we, input int hold);
        int base;
        csr309 = csrval;
        base   = wr_count;
        accept(ins, rs1);
        check({tag, "_read_wr"},    32'(bus.csr_wr_en),   32'd0);
        check({tag, "_read_addr"},  32'(bus.csr_addr),    32'(exp_addr));
        check({tag, "_read_op"},    32'(bus.csr_op),      32'd0);
        check({tag, "_read_rdy"},   32'(bus.instr_ready), 32'd0);
        step();
        check({tag, "_write_wr"},   32'(bus.csr_wr_en),   32'(exp_wr));
        check({tag, "_write_op"},   32'(bus.csr_op),      32'(exp_op));
        check({tag, "_write_uimm"}, 32'(bus.csr_uimm),    32'(exp_uimm));
        check({tag, "_write_addr"}, 32'(bus.csr_addr),    32'(exp_addr));
        if (exp_wr) check({tag, "_write_din"}, bus.csr_data_in, rs1);
        step();
        for (int i = 0; i <= hold; i++) begin
            check({tag, "_wb_valid"}, 32'(bus.wb_valid),    32'd1);
            check({tag, "_wb_ill"},   32'(bus.illegal),     32'd0);
            check({tag, "_wb_rd"},    32'(bus.wb_rd),       32'(exp_rd));
            check({tag, "_wb_data"},  bus.wb_data,          csrval);
            check({tag, "_wb_we"},    32'(bus.wb_we),       32'(exp_we));
            check({tag, "_wb_rdy"},   32'(bus.instr_ready), 32'd0);
            check({tag, "_wb_csrwr"}, 32'(bus.csr_wr_en),   32'd0);
            if (i < hold) step();
        end
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.wb_valid),    32'd0);
        check({tag, "_done_rdy"},   32'(bus.instr_ready), 32'd1);
        check({tag, "_pulses"},     32'(wr_count - base), 32'(exp_wr));
    endtask

    task automatic illegal_txn(input string tag, input logic [31:0] ins);
        int base;
        base = wr_count;
        accept(ins, 32'hFFFF_FFFF);
        check({tag, "_valid"}, 32'(bus.wb_valid),    32'd1);
        check({tag, "_ill"},   32'(bus.illegal),     32'd1);
        check({tag, "_we"},    32'(bus.wb_we),       32'd0);
        check({tag, "_data"},  bus.wb_data,          32'd0);
        check({tag, "_addr"},  32'(bus.csr_addr),    32'd0);
        check({tag, "_op"},    32'(bus.csr_op),      32'd0);
        check({tag, "_rdy"},   32'(bus.instr_ready), 32'd0);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.wb_valid),    32'd0);
        check({tag, "_done_rdy"},   32'(bus.instr_ready), 32'd1);
        check({tag, "_pulses"},     32'(wr_count - base), 32'd0);
    endtask

    initial begin
        int base;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.rs1_data    = 32'd0;
        bus.wb_ready    = 1'b0;
        step();
        step();
        check("rst_ready",  32'(bus.instr_ready), 32'd1);
        check("rst_valid",  32'(bus.wb_valid),    32'd0);
        check("rst_wr",     32'(bus.csr_wr_en),   32'd0);
        check("rst_addr",   32'(bus.csr_addr),    32'd0);
        check("rst_ill",    32'(bus.illegal),     32'd0);
        check("rst_wbdata", bus.wb_data,          32'd0);
        rst = 1'b0;
        step();

        // CSRRW x5, 0x309, x1
        legal_txn("rw", enc(12'h309, 5'd1, 3'b001, 5'd5, 7'h73), 32'hDEAD_BEEF,
                  32'h0000_0012, 12'h309, 1'b1, 3'b001, 5'd1, 5'd5, 1'b1, 0);
        // CSRRS x3, 0x309, x0: read only, no write pulse
        legal_txn("rs0", enc(12'h309, 5'd0, 3'b010, 5'd3, 7'h73), 32'h1111_1111,
                  32'h0000_00A5, 12'h309, 1'b0, 3'b000, 5'd0, 5'd3, 1'b1, 0);
        // CSRRCI x0, 0x309, 0x1F
        legal_txn("rci", enc(12'h309, 5'h1F, 3'b111, 5'd0, 7'h73), 32'hCAFE_0000,
                  32'h0000_005A, 12'h309, 1'b1, 3'b111, 5'h1F, 5'd0, 1'b0, 0);

        illegal_txn("bad_opc", enc(12'h309, 5'd1, 3'b001, 5'd5, 7'h33));
        illegal_txn("bad_f3",  enc(12'h309, 5'd1, 3'b100, 5'd5, 7'h73));

`ifdef CSR_RO_CHECK_EN
        illegal_txn("ro_rw", enc(12'hC00, 5'd1, 3'b001, 5'd5, 7'h73));
`else
        legal_txn("ro_rw", enc(12'hC00, 5'd1, 3'b001, 5'd5, 7'h73), 32'h0000_1234,
                  32'h0000_0077, 12'hC00, 1'b1, 3'b001, 5'd1, 5'd5, 1'b1, 0);
`endif
        // Read-only intent to the RO quadrant is always allowed
        legal_txn("ro_rs", enc(12'hC00, 5'd0, 3'b010, 5'd6, 7'h73), 32'h0,
                  32'h0000_0077, 12'hC00, 1'b0, 3'b000, 5'd0, 5'd6, 1'b1, 0);

        // Backpressure for 5 cycles, then immediate next accept
        legal_txn("bp", enc(12'h309, 5'd2, 3'b011, 5'd7, 7'h73), 32'h0000_00F0,
                  32'h0000_0F0F, 12'h309, 1'b1, 3'b011, 5'd2, 5'd7, 1'b1, 5);
        accept(enc(12'h309, 5'd1, 3'b001, 5'd9, 7'h73), 32'h1);
        check("bp_next_addr", 32'(bus.csr_addr),    32'h309);
        check("bp_next_rdy",  32'(bus.instr_ready), 32'd0);
        step();
        step();
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;

        // Reset while in READ drops the pending write
        base = wr_count;
        accept(enc(12'h309, 5'd1, 3'b001, 5'd5, 7'h73), 32'h5555_AAAA);
        check("mid_pre_addr", 32'(bus.csr_addr), 32'h309);
        rst = 1'b1;
        #1;
        check("mid_rdy",   32'(bus.instr_ready), 32'd1);
        check("mid_addr",  32'(bus.csr_addr),    32'd0);
        check("mid_wr",    32'(bus.csr_wr_en),   32'd0);
        check("mid_valid", 32'(bus.wb_valid),    32'd0);
        check("mid_rd",    32'(bus.wb_rd),       32'd0);
        check("mid_din",   bus.csr_data_in,      32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        check("mid_pulses", 32'(wr_count - base),  32'd0);
        check("mid_idle",   32'(bus.instr_ready),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
